// File: rtl/game_pkg.sv
// Shared definitions for the game controller family: state encoding and BCD helpers.
`default_nettype none

package game_pkg;

   typedef enum logic [2:0] {
      LAMP      = 3'd0,
      IDLE      = 3'd1,
      COUNTDOWN = 3'd2,
      PLAY      = 3'd3,
      PAUSE     = 3'd4,
      FINISH    = 3'd5
   } state_t;

   function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h99)
         r = v;
      else if (v[3:0] >= 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   // Floors at 00 so a stray tick can never wrap the display to 99.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h00)
         r = v;
      else if (v[3:0] == 4'd0)
         r = {v[7:4] - 4'd1, 4'd9};
      else
         r = {v[7:4], v[3:0] - 4'd1};
      return r;
   endfunction

   function automatic logic [7:0] to_bcd(input int unsigned n);
      logic [7:0] r;
      r[7:4] = 4'(n / 10);
      r[3:0] = 4'(n % 10);
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sec_tick_gen.sv
// One-second prescaler: counts 0..TICKS_PER_SEC-1 while run is high, tick on the last count.
`default_nettype none

module sec_tick_gen #(
   parameter int TICKS_PER_SEC = 100000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int CW = $clog2(TICKS_PER_SEC);
   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] count;

   assign tick = run && (count == LAST);

   always_ff @(posedge clk) begin
      if (rst || clear)
         count <= '0;
      else if (run)
         count <= tick ? '0 : count + 1'b1;
   end

endmodule

`default_nettype wire

// File: rtl/game_ctrl_multi.sv
// Multi-player timed game sequencer: lamp test, countdown, play/pause, finish with winner.
`default_nettype none

module game_ctrl_multi
   import game_pkg::*;
#(
   parameter int NUM_PLAYERS   = 2,
   parameter int PLAY_SECS     = 15,
   parameter int PRE_SECS      = 3,
   parameter int TICKS_PER_SEC = 100000000
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       pause,
   input  logic [NUM_PLAYERS-1:0]     goal,
   output logic [2:0]                 state,
   output logic [7:0]                 time_bcd,
   output logic [8*NUM_PLAYERS-1:0]   score_bcd,
   output logic [NUM_PLAYERS-1:0]     goal_ack,
   output logic                       sec_tick,
   output logic                       game_over,
   output logic [1:0]                 winner,
   output logic                       tie
);

   localparam logic [7:0] PRE_BCD  = to_bcd(PRE_SECS);
   localparam logic [7:0] PLAY_BCD = to_bcd(PLAY_SECS);

   state_t     cur_state, nxt_state;
   logic [7:0] time_q, nxt_time;
   logic       tick, run, clr, pp_swap;
   logic       restart, accept, final_tick;
   logic [8*NUM_PLAYERS-1:0] score_nx;
   logic [7:0] best;
   logic [1:0] win_idx;
   logic       tie_nx;

   assign run     = (cur_state == LAMP) || (cur_state == COUNTDOWN) || (cur_state == PLAY);
   assign pp_swap = ((cur_state == PLAY)  && (nxt_state == PAUSE)) ||
                    ((cur_state == PAUSE) && (nxt_state == PLAY));
   // PLAY<->PAUSE keeps the partial second so pausing neither gains nor loses time.
   assign clr     = ((nxt_state != cur_state) && !pp_swap) ||
                    (cur_state == IDLE) || (cur_state == FINISH);

   sec_tick_gen #(
      .TICKS_PER_SEC (TICKS_PER_SEC)
   ) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .clear (clr),
      .run   (run),
      .tick  (tick)
   );

   assign restart    = ((cur_state == IDLE) || (cur_state == FINISH)) && start;
   assign accept     = (cur_state == PLAY);
   assign final_tick = (cur_state == PLAY) && tick && (time_q == 8'h01);

   always_comb begin
      nxt_state = cur_state;
      nxt_time  = time_q;
      case (cur_state)
         LAMP: if (tick) nxt_state = IDLE;
         IDLE, FINISH: begin
            if (start) begin
               nxt_state = COUNTDOWN;
               nxt_time  = PRE_BCD;
            end
         end
         COUNTDOWN: begin
            if (tick) begin
               if (time_q == 8'h01) begin
                  nxt_state = PLAY;
                  nxt_time  = PLAY_BCD;
               end else begin
                  nxt_time = bcd_dec(time_q);
               end
            end
         end
         PLAY: begin
            if (tick) nxt_time = bcd_dec(time_q);
            if (final_tick)
               nxt_state = FINISH;
            else if (pause)
               nxt_state = PAUSE;
         end
         PAUSE: if (pause) nxt_state = PLAY;
         default: nxt_state = LAMP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         cur_state <= LAMP;
      else
         cur_state <= nxt_state;
   end

   for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
      logic [7:0] score_q;
      logic       ack_q;

      assign score_nx[8*i +: 8] = restart               ? 8'h00 :
                                  (accept && goal[i])   ? bcd_inc_sat(score_q) :
                                                          score_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            score_q <= 8'h00;
            ack_q   <= 1'b0;
         end else begin
            score_q <= score_nx[8*i +: 8];
            ack_q   <= accept && goal[i];
         end
      end

      assign score_bcd[8*i +: 8] = score_q;
      assign goal_ack[i]         = ack_q;
   end

   // Compare on next-cycle scores so a goal in the final-tick cycle counts toward the winner.
   always_comb begin
      best    = score_nx[7:0];
      win_idx = 2'd0;
      tie_nx  = 1'b0;
      for (int p = 1; p < NUM_PLAYERS; p++) begin
         if (score_nx[8*p +: 8] > best) begin
            best    = score_nx[8*p +: 8];
            win_idx = 2'(p);
            tie_nx  = 1'b0;
         end else if (score_nx[8*p +: 8] == best) begin
            tie_nx = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         time_q    <= 8'h00;
         sec_tick  <= 1'b0;
         game_over <= 1'b0;
         winner    <= 2'd0;
         tie       <= 1'b0;
      end else begin
         time_q    <= nxt_time;
         sec_tick  <= tick && ((cur_state == COUNTDOWN) || (cur_state == PLAY));
         game_over <= final_tick;
         if (restart) begin
            winner <= 2'd0;
            tie    <= 1'b0;
         end else if (final_tick) begin
            winner <= win_idx;
            tie    <= tie_nx;
         end
      end
   end

   assign state    = cur_state;
   assign time_bcd = time_q;

endmodule

`default_nettype wire

// File: tb/tb_game_ctrl_multi.sv
// Scoreboard bench for game_ctrl_multi: 2-player main instance plus a 1-player saturation instance.
`default_nettype none

module tb_game_ctrl_multi;

   localparam logic [2:0] S_LAMP = 3'd0, S_IDLE = 3'd1, S_CD = 3'd2,
                          S_PLAY = 3'd3, S_PAUSE = 3'd4, S_FIN = 3'd5;

   logic        clk = 1'b0;
   logic        rst, start, pause;
   logic [1:0]  goal;
   logic [2:0]  state;
   logic [7:0]  time_bcd;
   logic [15:0] score_bcd;
   logic [1:0]  goal_ack;
   logic        sec_tick, game_over, tie;
   logic [1:0]  winner;

   logic        start1, pause1;
   logic [0:0]  goal1;
   logic [2:0]  state1;
   logic [7:0]  time1, score1;
   logic [0:0]  ack1;
   logic        tick1, over1, tie1;
   logic [1:0]  winner1;

   always #5 clk = ~clk;

   game_ctrl_multi #(.NUM_PLAYERS(2), .PLAY_SECS(15), .PRE_SECS(3), .TICKS_PER_SEC(4)) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .goal(goal),
      .state(state), .time_bcd(time_bcd), .score_bcd(score_bcd), .goal_ack(goal_ack),
      .sec_tick(sec_tick), .game_over(game_over), .winner(winner), .tie(tie));

   game_ctrl_multi #(.NUM_PLAYERS(1), .PLAY_SECS(40), .PRE_SECS(1), .TICKS_PER_SEC(4)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .pause(pause1), .goal(goal1),
      .state(state1), .time_bcd(time1), .score_bcd(score1), .goal_ack(ack1),
      .sec_tick(tick1), .game_over(over1), .winner(winner1), .tie(tie1));

   typedef struct packed {
      logic [7:0] t;
      logic [2:0] st;
      logic [7:0] gap;
   } titem_t;

   titem_t     exp_t[$];
   logic [7:0] exp_s0[$];
   logic [7:0] exp_s1[$];
   int         sc[2];
   int         n_chk = 0, n_pass = 0;
   int         cyc = 0, last_tick = 0, go_count = 0;
   logic [2:0] prev_state = 3'd0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
   endtask

   function automatic logic [7:0] bcd8(input int n);
      return 8'((n / 10) * 16 + (n % 10));
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_tick(input logic [7:0] t, input logic [2:0] st, input int gap);
      titem_t e;
      e.t = t; e.st = st; e.gap = 8'(gap);
      exp_t.push_back(e);
   endtask

   task automatic push_game(input logic [7:0] no_gap_t, input bit full);
      push_tick(8'h02, S_CD, 0);
      push_tick(8'h01, S_CD, 4);
      push_tick(8'h15, S_PLAY, 4);
      if (full) begin
         for (int n = 14; n >= 1; n--)
            push_tick(bcd8(n), S_PLAY, (bcd8(n) == no_gap_t) ? 0 : 4);
         push_tick(8'h00, S_FIN, 4);
      end
   endtask

   task automatic goal_pulse(input logic [1:0] g);
      for (int p = 0; p < 2; p++) begin
         if (g[p]) begin
            sc[p] = (sc[p] < 99) ? sc[p] + 1 : 99;
            if (p == 0) exp_s0.push_back(bcd8(sc[p]));
            else        exp_s1.push_back(bcd8(sc[p]));
         end
      end
      goal = g;
      step(1);
      goal = 2'b00;
   endtask

   task automatic wait_time(input logic [7:0] t, input logic [2:0] st);
      for (int i = 0; i < 3000 && !(time_bcd == t && state == st); i++)
         step(1);
      check("wait_time", {state, time_bcd}, {st, t});
   endtask

   task automatic do_start(input logic with_pause);
      sc[0] = 0; sc[1] = 0;
      start = 1'b1; pause = with_pause;
      step(1);
      start = 1'b0; pause = 1'b0;
      check("start_state", state, S_CD);
      check("start_time", time_bcd, 8'h03);
      check("start_scores", score_bcd, 16'h0000);
      check("start_winner_tie", {winner, tie}, 3'b000);
   endtask

   // Scoreboard side: pops expectations when the DUT produces ticks, acks, game_over.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (sec_tick) begin
            if (exp_t.size() == 0) check("sec_tick_unexpected", 1, 0);
            else begin
               titem_t e;
               e = exp_t.pop_front();
               check("tick_time", time_bcd, e.t);
               check("tick_state", state, e.st);
               if (e.gap != 0) check("tick_gap", cyc - last_tick, e.gap);
            end
            last_tick = cyc;
         end
         if (goal_ack[0]) begin
            if (exp_s0.size() == 0) check("ack0_unexpected", 1, 0);
            else check("score0", score_bcd[7:0], exp_s0.pop_front());
         end
         if (goal_ack[1]) begin
            if (exp_s1.size() == 0) check("ack1_unexpected", 1, 0);
            else check("score1", score_bcd[15:8], exp_s1.pop_front());
         end
         if (game_over) begin
            go_count++;
            check("game_over_entry", {prev_state, state}, {S_PLAY, S_FIN});
         end
      end
      prev_state = state;
   end

   initial begin
      rst = 1'b1; start = 1'b0; pause = 1'b0; goal = 2'b00;
      start1 = 1'b0; pause1 = 1'b0; goal1 = 1'b0;
      sc[0] = 0; sc[1] = 0;
      step(3);
      check("rst_state", state, S_LAMP);
      check("rst_time", time_bcd, 8'h00);
      check("rst_scores", score_bcd, 16'h0000);
      check("rst_pulses", {goal_ack, sec_tick, game_over}, 4'b0000);
      check("rst_winner_tie", {winner, tie}, 3'b000);
      rst = 1'b0;
      step(3);
      check("lamp_hold", state, S_LAMP);
      step(1);
      check("lamp_to_idle", state, S_IDLE);

      // Game 1: goals to a 3/3 tie, pause mid-second, goal on the final tick.
      push_game(8'h11, 1'b1);
      do_start(1'b1);
      wait_time(8'h14, S_PLAY);
      goal_pulse(2'b01);
      goal_pulse(2'b10);
      goal_pulse(2'b11);
      goal_pulse(2'b01);
      wait_time(8'h12, S_PLAY);
      step(2);
      pause = 1'b1;
      step(1);
      pause = 1'b0;
      check("pause_enter", state, S_PAUSE);
      for (int k = 0; k < 50; k++) begin
         goal  = (k % 10 == 0) ? 2'b11 : 2'b00;
         start = (k == 25);
         step(1);
         goal = 2'b00; start = 1'b0;
      end
      check("pause_state", state, S_PAUSE);
      check("pause_time", time_bcd, 8'h12);
      check("pause_scores", score_bcd, 16'h0203);
      pause = 1'b1;
      step(1);
      pause = 1'b0;
      check("resume_state", state, S_PLAY);
      check("resume_no_tick", sec_tick, 1'b0);
      step(1);
      check("resume_tick", {sec_tick, time_bcd}, {1'b1, 8'h11});
      wait_time(8'h01, S_PLAY);
      step(3);
      goal_pulse(2'b10);
      check("g1_finish", {state, time_bcd}, {S_FIN, 8'h00});
      check("g1_game_over", game_over, 1'b1);
      check("g1_scores", score_bcd, 16'h0303);
      check("g1_winner_tie", {winner, tie}, {2'd0, 1'b1});
      step(1);
      check("g1_game_over_single", game_over, 1'b0);

      // Game 2: 12 vs 7, final tick together with pause.
      push_game(8'hFF, 1'b1);
      do_start(1'b0);
      wait_time(8'h15, S_PLAY);
      for (int k = 0; k < 12; k++) begin
         goal_pulse((k < 7) ? 2'b11 : 2'b01);
         step(1);
      end
      wait_time(8'h01, S_PLAY);
      step(3);
      pause = 1'b1;
      step(1);
      pause = 1'b0;
      check("g2_finish", state, S_FIN);
      check("g2_scores", score_bcd, 16'h0712);
      check("g2_winner_tie", {winner, tie}, {2'd0, 1'b0});
      step(5);
      check("g2_hold", {state, winner, tie}, {S_FIN, 2'd0, 1'b0});

      // Game 3: reset in the middle of play.
      push_game(8'hFF, 1'b0);
      do_start(1'b0);
      wait_time(8'h15, S_PLAY);
      goal_pulse(2'b01);
      step(1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      sc[0] = 0; sc[1] = 0;
      check("mid_rst_state", state, S_LAMP);
      check("mid_rst_scores", score_bcd, 16'h0000);
      check("mid_rst_time", time_bcd, 8'h00);
      check("mid_rst_ack", goal_ack, 2'b00);
      step(4);
      check("mid_rst_idle", state, S_IDLE);

      // Single-player instance: saturation at 99, winner/tie stay 0.
      for (int i = 0; i < 20 && state1 != S_IDLE; i++) step(1);
      check("u1_idle", state1, S_IDLE);
      start1 = 1'b1;
      step(1);
      start1 = 1'b0;
      for (int i = 0; i < 50 && state1 != S_PLAY; i++) step(1);
      check("u1_play", state1, S_PLAY);
      for (int k = 1; k <= 100; k++) begin
         goal1 = 1'b1;
         step(1);
         if (k == 1 || k == 9 || k == 10 || k == 99 || k == 100) begin
            check($sformatf("u1_score_%0d", k), score1, bcd8((k < 99) ? k : 99));
            check($sformatf("u1_ack_%0d", k), ack1, 1'b1);
         end
      end
      goal1 = 1'b0;
      step(1);
      check("u1_ack_off", ack1, 1'b0);
      for (int i = 0; i < 400 && state1 != S_FIN; i++) step(1);
      check("u1_finish", {state1, score1}, {S_FIN, 8'h99});
      check("u1_winner_tie", {winner1, tie1}, 3'b000);

      check("time_q_empty", exp_t.size(), 0);
      check("ack_q_empty", exp_s0.size() + exp_s1.size(), 0);
      check("game_over_count", go_count, 2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
